// File: rtl/rsenc_lfsr_if.sv
// Symbol-stream bundle between the RS encoder and its neighbours:
// message symbols in, codeword symbols (with framing flags) out.
interface rsenc_lfsr_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;
    logic       out_par;

    // master: the side feeding messages and draining codewords
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop, out_par
    );

    // slave: the encoder
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop, out_par
    );
endinterface

// File: rtl/rsenc_lfsr.sv
// Systematic RS(K+NPAR, K) encoder over GF(2^8)/0x187, g(x) = prod (x + alpha^i), i=0..NPAR-1.
// Define RSENC_SHORTEN_EN to add a per-codeword k_len input for shortened codes.

// One LFSR tap: r <= prev ^ fb*G, with G fixed at elaboration so the product is an XOR network.
module rsenc_lfsr_tap #(
    parameter logic [7:0] G = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] fb,
    input  logic [7:0] prev,
    output logic [7:0] r
);
    logic [7:0] prod;

    always_comb begin
        logic [7:0] col;
        prod = '0;
        col  = G;
        for (int b = 0; b < 8; b++) begin
            if (fb[b]) prod = prod ^ col;
            col = {col[6:0], 1'b0} ^ (col[7] ? 8'h87 : 8'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r <= '0;
        else if (clear) r <= '0;
        else if (en)    r <= prev ^ prod;
    end
endmodule

module rsenc_lfsr #(
    parameter int NPAR = 32,
    parameter int K    = 223
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
`ifdef RSENC_SHORTEN_EN
    input  logic [7:0]       k_len,
`endif
    rsenc_lfsr_if.slave      bus
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h87 : 8'h00);
        end
        return acc;
    endfunction

    // Monic generator; the x^NPAR coefficient (1) is implicit in the feedback.
    function automatic logic [NPAR*8-1:0] gen_poly();
        logic [NPAR:0][7:0] p;
        logic [7:0]         a;
        p    = '0;
        p[0] = 8'h01;
        a    = 8'h01;
        for (int i = 0; i < NPAR; i++) begin
            for (int j = NPAR; j > 0; j--) p[j] = p[j-1] ^ gf_mul(p[j], a);
            p[0] = gf_mul(p[0], a);
            a    = gf_mul(a, 8'h02);
        end
        return p[NPAR-1:0];
    endfunction

    localparam logic [NPAR-1:0][7:0] GEN   = gen_poly();
    localparam logic [7:0]           K8    = 8'(K);
    localparam logic [7:0]           PLAST = 8'(NPAR - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t               state, state_d;
    logic [7:0]           dcnt, dcnt_d;
    logic [7:0]           pcnt, pcnt_d;
    logic [NPAR-1:0][7:0] r;
    logic [7:0]           fb;
    logic                 free, in_xfer, par_step, lfsr_en;
    logic                 ov_q, ov_d, sop_q, sop_d, eop_q, eop_d, par_q, par_d;
    logic [7:0]           od_q, od_d;
    logic [7:0]           k_in, klen_q;

`ifdef RSENC_SHORTEN_EN
    assign k_in = (k_len == 8'd0 || k_len > K8) ? K8 : k_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                      klen_q <= K8;
        else if (!clear && state == IDLE && in_xfer)     klen_q <= k_in;
    end
`else
    assign k_in   = K8;
    assign klen_q = K8;
`endif

    assign free         = !ov_q || bus.out_ready;
    assign bus.in_ready = free && (state == IDLE || state == DATA);
    assign in_xfer      = bus.in_valid && bus.in_ready && !clear;
    assign par_step     = (state == PARITY) && free && !clear;
    assign lfsr_en      = in_xfer || par_step;
    // Draining parity is the same update with zero feedback: a plain shift toward r[NPAR-1].
    assign fb           = (state == PARITY) ? 8'h00 : (bus.in_data ^ r[NPAR-1]);

    for (genvar j = 0; j < NPAR; j++) begin : g_tap
        logic [7:0] prev;
        if (j == 0) begin : g_first
            assign prev = 8'h00;
        end else begin : g_rest
            assign prev = r[j-1];
        end
        rsenc_lfsr_tap #(.G(GEN[j])) u_tap (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (clear),
            .en    (lfsr_en),
            .fb    (fb),
            .prev  (prev),
            .r     (r[j])
        );
    end

    always_comb begin
        state_d = state;
        dcnt_d  = dcnt;
        pcnt_d  = pcnt;
        ov_d    = free ? 1'b0 : ov_q;
        od_d    = od_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        par_d   = par_q;
        case (state)
            IDLE: if (in_xfer) begin
                ov_d   = 1'b1;
                od_d   = bus.in_data;
                sop_d  = 1'b1;
                eop_d  = 1'b0;
                par_d  = 1'b0;
                dcnt_d = 8'd1;
                pcnt_d = 8'd0;
                state_d = (k_in == 8'd1) ? PARITY : DATA;
            end
            DATA: if (in_xfer) begin
                ov_d   = 1'b1;
                od_d   = bus.in_data;
                sop_d  = 1'b0;
                eop_d  = 1'b0;
                par_d  = 1'b0;
                dcnt_d = dcnt + 8'd1;
                if (dcnt == klen_q - 8'd1) begin
                    state_d = PARITY;
                    pcnt_d  = 8'd0;
                end
            end
            PARITY: if (par_step) begin
                ov_d   = 1'b1;
                od_d   = r[NPAR-1];
                sop_d  = 1'b0;
                par_d  = 1'b1;
                eop_d  = (pcnt == PLAST);
                pcnt_d = pcnt + 8'd1;
                if (pcnt == PLAST) begin
                    state_d = IDLE;
                    pcnt_d  = 8'd0;
                    dcnt_d  = 8'd0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over any transfer decided above, including the pending output beat.
        if (clear) begin
            state_d = IDLE;
            dcnt_d  = 8'd0;
            pcnt_d  = 8'd0;
            ov_d    = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            par_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dcnt  <= '0;
            pcnt  <= '0;
            ov_q  <= 1'b0;
            od_q  <= '0;
            sop_q <= 1'b0;
            eop_q <= 1'b0;
            par_q <= 1'b0;
        end else begin
            state <= state_d;
            dcnt  <= dcnt_d;
            pcnt  <= pcnt_d;
            ov_q  <= ov_d;
            od_q  <= od_d;
            sop_q <= sop_d;
            eop_q <= eop_d;
            par_q <= par_d;
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_sop   = sop_q;
    assign bus.out_eop   = eop_q;
    assign bus.out_par   = par_q;
endmodule
